// File: rtl/d_ff_reset_pkg.sv
// -----------------------------------------------------------------------------
// d_ff_reset_pkg
// Shared constants and types for the d_ff_reset_amisha register family.
//   DFF_DEFAULT_WIDTH       : default data width (1 bit)
//   DFF_DEFAULT_RESET_VALUE : default value loaded on reset (0)
//   dff_word_t              : data word at the default width, for parent designs
// -----------------------------------------------------------------------------
package d_ff_reset_pkg;

    localparam int DFF_DEFAULT_WIDTH       = 1;
    localparam int DFF_DEFAULT_RESET_VALUE = 0;

    typedef logic [DFF_DEFAULT_WIDTH-1:0] dff_word_t;

endpackage : d_ff_reset_pkg

// File: rtl/d_ff_reset_bit.sv
// -----------------------------------------------------------------------------
// d_ff_reset_bit
// Single-bit D flip-flop with asynchronous active-high reset and clock enable.
// Parameters:
//   RESET_VAL    : value forced onto q_amisha while reset_amisha is high
// Ports:
//   clk_amisha   : in  clock, rising-edge active
//   reset_amisha : in  asynchronous reset, active-high, dominant over enable
//   en_amisha    : in  load enable; tie high for an unconditional flop
//   d_amisha     : in  data
//   q_amisha     : out registered data
// -----------------------------------------------------------------------------
module d_ff_reset_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic en_amisha,
    input  logic d_amisha,
    output logic q_amisha
);

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            q_amisha <= RESET_VAL;
        end else if (en_amisha) begin
            q_amisha <= d_amisha;
        end
    end

endmodule : d_ff_reset_bit

// File: rtl/d_ff_reset_amisha.sv
// -----------------------------------------------------------------------------
// d_ff_reset_amisha
// Parameterised D register with asynchronous active-high reset. Built from
// WIDTH single-bit flops, each bit taking its own bit of RESET_VALUE.
// Optional feature macro: D_FF_RESET_CE_EN adds the en_amisha clock enable;
// without it every rising edge (reset low) loads d_amisha.
// Parameters:
//   WIDTH        : data width in bits (>= 1)
//   RESET_VALUE  : WIDTH-bit value loaded on reset
// Ports:
//   clk_amisha   : in  clock, rising-edge active
//   reset_amisha : in  asynchronous reset, active-high
//   d_amisha     : in  data, WIDTH bits
//   en_amisha    : in  load enable (only with D_FF_RESET_CE_EN)
//   q_amisha     : out registered data, WIDTH bits
// -----------------------------------------------------------------------------
module d_ff_reset_amisha
    import d_ff_reset_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF_DEFAULT_RESET_VALUE)
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic [WIDTH-1:0] d_amisha,
`ifdef D_FF_RESET_CE_EN
    input  logic             en_amisha,
`endif
    output logic [WIDTH-1:0] q_amisha
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_reset_bit #(
            .RESET_VAL (RESET_VALUE[i])
        ) u_bit (
            .clk_amisha   (clk_amisha),
            .reset_amisha (reset_amisha),
`ifdef D_FF_RESET_CE_EN
            .en_amisha    (en_amisha),
`else
            .en_amisha    (1'b1),
`endif
            .d_amisha     (d_amisha[i]),
            .q_amisha     (q_amisha[i])
        );
    end

endmodule : d_ff_reset_amisha

// File: tb/tb_d_ff_reset_amisha.sv
// -----------------------------------------------------------------------------
// tb_d_ff_reset_amisha
// Directed bench for d_ff_reset_amisha: a default 1-bit instance and an
// 8-bit instance with reset value 8'hA5. The clock is driven by hand so that
// it can be held high or low while reset and data move.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_d_ff_reset_amisha;

    logic       clk_amisha;
    logic       rst1;
    logic       d1;
    logic       q1;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       en;

    int checks   = 0;
    int failures = 0;

    d_ff_reset_amisha u_dut1 (
        .clk_amisha   (clk_amisha),
        .reset_amisha (rst1),
        .d_amisha     (d1),
`ifdef D_FF_RESET_CE_EN
        .en_amisha    (1'b1),
`endif
        .q_amisha     (q1)
    );

    d_ff_reset_amisha #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk_amisha   (clk_amisha),
        .reset_amisha (rst8),
        .d_amisha     (d8),
`ifdef D_FF_RESET_CE_EN
        .en_amisha    (en),
`endif
        .q_amisha     (q8)
    );

    task automatic check_val(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full clock: low half then rising edge; sample 1 ns after the edge.
    task automatic rise_edge();
        clk_amisha = 1'b0;
        #5;
        clk_amisha = 1'b1;
        #1;
    endtask

    initial begin
        clk_amisha = 1'b0;
        rst1 = 1'b1;
        d1   = 1'b0;
        rst8 = 1'b1;
        d8   = 8'h00;
        en   = 1'b1;
        #100;
        check_val("por_q1", {7'b0, q1}, 8'h00);
        check_val("por_q8", q8, 8'hA5);

        // Rising edge and data changes while reset is held
        clk_amisha = 1'b1;
        #5;
        check_val("rst_edge_d0", {7'b0, q1}, 8'h00);
        d1 = 1'b1;
        #5;
        check_val("rst_hold_d1", {7'b0, q1}, 8'h00);

        // Release with clock high; d toggles; falling edge must not capture
        rst1 = 1'b0;
        #5;
        d1 = 1'b0;
        #2;
        d1 = 1'b1;
        #3;
        check_val("release_clk_high", {7'b0, q1}, 8'h00);
        clk_amisha = 1'b0;
        #5;
        check_val("falling_edge", {7'b0, q1}, 8'h00);

        // First capture after release
        d1 = 1'b1;
        clk_amisha = 1'b1;
        #1;
        check_val("capture_1", {7'b0, q1}, 8'h01);
        d1 = 1'b0;
        #4;
        clk_amisha = 1'b0;
        #5;
        check_val("hold_between_edges", {7'b0, q1}, 8'h01);
        clk_amisha = 1'b1;
        #1;
        check_val("capture_0", {7'b0, q1}, 8'h00);

        // Reload a 1, then assert reset asynchronously with the clock steady
        d1 = 1'b1;
        #4;
        rise_edge();
        check_val("reload_1", {7'b0, q1}, 8'h01);
        #4;
        clk_amisha = 1'b0;
        #2;
        rst1 = 1'b1;
        #1;
        check_val("async_assert", {7'b0, q1}, 8'h00);
        #2;
        clk_amisha = 1'b1;
        #1;
        check_val("rst_over_edge", {7'b0, q1}, 8'h00);

        // Release mid-high phase: value stays until the next rising edge
        rst1 = 1'b0;
        #3;
        check_val("release_no_load", {7'b0, q1}, 8'h00);
        rise_edge();
        check_val("post_release_capture", {7'b0, q1}, 8'h01);

        // 8-bit instance: reset value, release, capture
        check_val("w8_reset_val", q8, 8'hA5);
        clk_amisha = 1'b0;
        #2;
        rst8 = 1'b0;
        d8   = 8'h3C;
        #2;
        check_val("w8_release_hold", q8, 8'hA5);
        rise_edge();
        check_val("w8_capture", q8, 8'h3C);

`ifdef D_FF_RESET_CE_EN
        en = 1'b0;
        d8 = 8'hFF;
        #4;
        rise_edge();
        check_val("ce_hold", q8, 8'h3C);
        en = 1'b1;
        #4;
        rise_edge();
        check_val("ce_load", q8, 8'hFF);
        en = 1'b0;
        #2;
        rst8 = 1'b1;
        #1;
        check_val("ce_reset", q8, 8'hA5);
`else
        d8 = 8'h5A;
        #4;
        rise_edge();
        check_val("w8_capture2", q8, 8'h5A);
        #2;
        rst8 = 1'b1;
        #1;
        check_val("w8_async_reset", q8, 8'hA5);
`endif

        #5;
        clk_amisha = 1'b0;
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_d_ff_reset_amisha
